// File: rtl/axi4_pkg.sv
// Shared AXI4 encodings and channel state types for the memory responder.
package axi4_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } wr_state_t;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rd_state_t;

  // Burst shapes this responder refuses: oversize beats, reserved type, odd wrap lengths.
  function automatic logic burst_illegal(input logic [2:0] size, input logic [7:0] len,
                                         input logic [1:0] burst);
    logic wrap_len_ok;
    wrap_len_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    return (size > 3'd2) || (burst == 2'b11) || ((burst == BURST_WRAP) && !wrap_len_ok);
  endfunction

endpackage

// File: rtl/axi4_burst_addr.sv
// Next-beat address for FIXED/INCR/WRAP bursts; reserved burst type steps like INCR.
module axi4_burst_addr
  import axi4_pkg::*;
#(
  parameter int AW = 16
) (
  input  logic [AW-1:0] addr,
  input  logic [2:0]    size,
  input  logic [7:0]    len,
  input  logic [1:0]    burst,
  output logic [AW-1:0] next_addr
);

  logic [AW-1:0] step;
  logic [AW-1:0] span_mask;
  logic [AW-1:0] incr_addr;

  always_comb begin
    step      = AW'(1) << size;
    // Only meaningful for power-of-two spans; other wrap lengths are already errored.
    span_mask = (AW'({1'b0, len} + 9'd1) << size) - AW'(1);
    incr_addr = addr + step;
    case (burst)
      BURST_FIXED: next_addr = addr;
      BURST_WRAP:  next_addr = (addr & ~span_mask) | (incr_addr & span_mask);
      default:     next_addr = incr_addr;
    endcase
  end

endmodule

// File: rtl/axi4_mem_responder.sv
// AXI4 slave terminating a master onto a word-addressed memory; independent
// write and read channels, one outstanding burst each, all outputs registered.
//
// state  | meaning
// W_IDLE | AWREADY high, waiting for a write address
// W_DATA | WREADY high, accepting AWLEN+1 data beats
// W_RESP | BVALID high, holding the burst response until BREADY
// R_IDLE | ARREADY high, waiting for a read address
// R_DATA | RVALID high, presenting ARLEN+1 beats
module axi4_mem_responder
  import axi4_pkg::*;
#(
  parameter int AXI4_ADDRESS_WIDTH = 16,
  parameter int AXI4_DATA_WIDTH    = 32,
  parameter int AXI4_ID_WIDTH      = 18,
  parameter int AXI4_USER_WIDTH    = 8,
  parameter int MEM_WORDS          = 1024
) (
  input  logic                          ACLK,
  input  logic                          ARESETn,
  input  logic                          AWVALID,
  input  logic [AXI4_ADDRESS_WIDTH-1:0] AWADDR,
  input  logic [AXI4_ID_WIDTH-1:0]      AWID,
  input  logic [7:0]                    AWLEN,
  input  logic [2:0]                    AWSIZE,
  input  logic [1:0]                    AWBURST,
  input  logic                          AWLOCK,
  input  logic [3:0]                    AWCACHE,
  input  logic [2:0]                    AWPROT,
  input  logic [3:0]                    AWQOS,
  input  logic [3:0]                    AWREGION,
  input  logic [AXI4_USER_WIDTH-1:0]    AWUSER,
  output logic                          AWREADY,
  input  logic                          WVALID,
  input  logic [AXI4_DATA_WIDTH-1:0]    WDATA,
  input  logic [3:0]                    WSTRB,
  input  logic                          WLAST,
  input  logic [AXI4_USER_WIDTH-1:0]    WUSER,
  output logic                          WREADY,
  output logic                          BVALID,
  output logic [1:0]                    BRESP,
  output logic [AXI4_ID_WIDTH-1:0]      BID,
  output logic [AXI4_USER_WIDTH-1:0]    BUSER,
  input  logic                          BREADY,
  input  logic                          ARVALID,
  input  logic [AXI4_ADDRESS_WIDTH-1:0] ARADDR,
  input  logic [AXI4_ID_WIDTH-1:0]      ARID,
  input  logic [7:0]                    ARLEN,
  input  logic [2:0]                    ARSIZE,
  input  logic [1:0]                    ARBURST,
  input  logic                          ARLOCK,
  input  logic [3:0]                    ARCACHE,
  input  logic [2:0]                    ARPROT,
  input  logic [3:0]                    ARQOS,
  input  logic [3:0]                    ARREGION,
  input  logic [AXI4_USER_WIDTH-1:0]    ARUSER,
  output logic                          ARREADY,
  output logic                          RVALID,
  output logic [AXI4_DATA_WIDTH-1:0]    RDATA,
  output logic [1:0]                    RRESP,
  output logic                          RLAST,
  output logic [AXI4_ID_WIDTH-1:0]      RID,
  output logic [AXI4_USER_WIDTH-1:0]    RUSER,
  input  logic                          RREADY
);

  localparam int AW    = AXI4_ADDRESS_WIDTH;
  localparam int AWP   = AXI4_ADDRESS_WIDTH + 1;
  localparam int IDX_W = $clog2(MEM_WORDS);
  localparam logic [AWP-1:0] MEM_BYTES = AWP'(MEM_WORDS * 4);

  function automatic logic [IDX_W-1:0] word_idx(input logic [AW-1:0] a);
    return a[IDX_W+1:2];
  endfunction

  logic [AXI4_DATA_WIDTH-1:0] mem [MEM_WORDS];

  logic unused_inputs;
  assign unused_inputs = ^{AWLOCK, AWCACHE, AWPROT, AWQOS, AWREGION, WUSER,
                           ARLOCK, ARCACHE, ARPROT, ARQOS, ARREGION};

  // ---------------- write channel ----------------
  wr_state_t                  wr_state, wr_next;
  logic [AW-1:0]              w_addr, w_addr_nxt;
  logic [7:0]                 w_len, w_left;
  logic [2:0]                 w_size;
  logic [1:0]                 w_burst;
  logic [AXI4_ID_WIDTH-1:0]   w_id;
  logic [AXI4_USER_WIDTH-1:0] w_user;
  logic                       w_illegal, w_lastbad, w_dec;
  logic                       aw_hs, w_hs, b_hs, w_final, w_beat_dec, w_last_bad, mem_we;

  assign aw_hs      = AWVALID && AWREADY;
  assign w_hs       = WVALID && WREADY;
  assign b_hs       = BVALID && BREADY;
  assign w_final    = (w_left == 8'd0);
  assign w_beat_dec = ({1'b0, w_addr} >= MEM_BYTES);
  assign w_last_bad = (WLAST != w_final);
  assign mem_we     = w_hs && !w_illegal && !w_beat_dec;

  axi4_burst_addr #(.AW(AW)) u_waddr (
    .addr(w_addr), .size(w_size), .len(w_len), .burst(w_burst), .next_addr(w_addr_nxt)
  );

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) wr_state <= W_IDLE;
    else          wr_state <= wr_next;
  end

  always_comb begin
    wr_next = wr_state;
    case (wr_state)
      W_IDLE:  if (aw_hs) wr_next = W_DATA;
      W_DATA:  if (w_hs && w_final) wr_next = W_RESP;
      W_RESP:  if (b_hs) wr_next = W_IDLE;
      default: wr_next = W_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      AWREADY   <= 1'b0;
      WREADY    <= 1'b0;
      BVALID    <= 1'b0;
      BRESP     <= RESP_OKAY;
      BID       <= '0;
      BUSER     <= '0;
      w_addr    <= '0;
      w_len     <= '0;
      w_left    <= '0;
      w_size    <= '0;
      w_burst   <= '0;
      w_id      <= '0;
      w_user    <= '0;
      w_illegal <= 1'b0;
      w_lastbad <= 1'b0;
      w_dec     <= 1'b0;
    end else begin
      AWREADY <= (wr_next == W_IDLE);
      WREADY  <= (wr_next == W_DATA);
      BVALID  <= (wr_next == W_RESP);
      if (aw_hs) begin
        w_addr    <= AWADDR;
        w_len     <= AWLEN;
        w_left    <= AWLEN;
        w_size    <= AWSIZE;
        w_burst   <= AWBURST;
        w_id      <= AWID;
        w_user    <= AWUSER;
        w_illegal <= burst_illegal(AWSIZE, AWLEN, AWBURST);
        w_lastbad <= 1'b0;
        w_dec     <= 1'b0;
      end else if (w_hs) begin
        w_addr    <= w_addr_nxt;
        w_left    <= w_left - 8'd1;
        w_lastbad <= w_lastbad | w_last_bad;
        w_dec     <= w_dec | w_beat_dec;
        if (w_final) begin
          BID   <= w_id;
          BUSER <= w_user;
          if (w_dec || w_beat_dec)                         BRESP <= RESP_DECERR;
          else if (w_illegal || w_lastbad || w_last_bad) BRESP <= RESP_SLVERR;
          else                                             BRESP <= RESP_OKAY;
        end
      end
    end
  end

  // Memory has no reset so its contents survive ARESETn.
  always_ff @(posedge ACLK) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (WSTRB[b]) mem[word_idx(w_addr)][8*b +: 8] <= WDATA[8*b +: 8];
      end
    end
  end

  // ---------------- read channel ----------------
  rd_state_t                  rd_state, rd_next;
  logic [AW-1:0]              r_addr, r_addr_nxt, r_fetch_addr;
  logic [7:0]                 r_len, r_left;
  logic [2:0]                 r_size;
  logic [1:0]                 r_burst;
  logic                       r_illegal, fetch_illegal, fetch_dec;
  logic [AXI4_DATA_WIDTH-1:0] fetch_word;
  logic                       ar_hs, r_hs, r_final;

  assign ar_hs   = ARVALID && ARREADY;
  assign r_hs    = RVALID && RREADY;
  assign r_final = (r_left == 8'd0);

  axi4_burst_addr #(.AW(AW)) u_raddr (
    .addr(r_addr), .size(r_size), .len(r_len), .burst(r_burst), .next_addr(r_addr_nxt)
  );

  // First beat comes straight from the AR channel, later beats from the stepped address.
  always_comb begin
    r_fetch_addr  = (rd_state == R_IDLE) ? ARADDR : r_addr_nxt;
    fetch_illegal = (rd_state == R_IDLE) ? burst_illegal(ARSIZE, ARLEN, ARBURST) : r_illegal;
    fetch_dec     = ({1'b0, r_fetch_addr} >= MEM_BYTES);
    fetch_word    = mem[word_idx(r_fetch_addr)];
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) rd_state <= R_IDLE;
    else          rd_state <= rd_next;
  end

  always_comb begin
    rd_next = rd_state;
    case (rd_state)
      R_IDLE:  if (ar_hs) rd_next = R_DATA;
      R_DATA:  if (r_hs && r_final) rd_next = R_IDLE;
      default: rd_next = R_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      ARREADY   <= 1'b0;
      RVALID    <= 1'b0;
      RDATA     <= '0;
      RRESP     <= RESP_OKAY;
      RLAST     <= 1'b0;
      RID       <= '0;
      RUSER     <= '0;
      r_addr    <= '0;
      r_len     <= '0;
      r_left    <= '0;
      r_size    <= '0;
      r_burst   <= '0;
      r_illegal <= 1'b0;
    end else begin
      ARREADY <= (rd_next == R_IDLE);
      RVALID  <= (rd_next == R_DATA);
      if (ar_hs) begin
        r_addr    <= ARADDR;
        r_len     <= ARLEN;
        r_left    <= ARLEN;
        r_size    <= ARSIZE;
        r_burst   <= ARBURST;
        r_illegal <= fetch_illegal;
        RID       <= ARID;
        RUSER     <= ARUSER;
        RLAST     <= (ARLEN == 8'd0);
      end else if (r_hs) begin
        r_addr <= r_addr_nxt;
        r_left <= r_left - 8'd1;
        RLAST  <= (r_left == 8'd1);
      end
      if (ar_hs || (r_hs && !r_final)) begin
        RDATA <= (fetch_dec || fetch_illegal) ? '0 : fetch_word;
        if (fetch_dec)          RRESP <= RESP_DECERR;
        else if (fetch_illegal) RRESP <= RESP_SLVERR;
        else                    RRESP <= RESP_OKAY;
      end
    end
  end

endmodule

// File: tb/tb_axi4_mem_responder.sv
// Scoreboard bench for axi4_mem_responder: expected B/R responses queued at stimulus time.
`timescale 1ns/1ps
module tb_axi4_mem_responder;

  localparam int MW = 1024;

  logic        ACLK = 1'b0;
  logic        ARESETn = 1'b0;
  logic        AWVALID = 0, AWLOCK = 0, WVALID = 0, WLAST = 0, BREADY = 0;
  logic [15:0] AWADDR = 0, ARADDR = 0;
  logic [17:0] AWID = 0, ARID = 0;
  logic [7:0]  AWLEN = 0, ARLEN = 0, AWUSER = 0, ARUSER = 0, WUSER = 0;
  logic [2:0]  AWSIZE = 0, ARSIZE = 0, AWPROT = 0, ARPROT = 0;
  logic [1:0]  AWBURST = 0, ARBURST = 0;
  logic [3:0]  AWCACHE = 0, AWQOS = 0, AWREGION = 0, ARCACHE = 0, ARQOS = 0, ARREGION = 0;
  logic [31:0] WDATA = 0;
  logic [3:0]  WSTRB = 0;
  logic        ARVALID = 0, ARLOCK = 0, RREADY = 0;
  logic        AWREADY, WREADY, BVALID, ARREADY, RVALID, RLAST;
  logic [1:0]  BRESP, RRESP;
  logic [17:0] BID, RID;
  logic [7:0]  BUSER, RUSER;
  logic [31:0] RDATA;

  always #5 ACLK = ~ACLK;

  axi4_mem_responder dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .AWVALID(AWVALID), .AWADDR(AWADDR), .AWID(AWID), .AWLEN(AWLEN), .AWSIZE(AWSIZE),
    .AWBURST(AWBURST), .AWLOCK(AWLOCK), .AWCACHE(AWCACHE), .AWPROT(AWPROT), .AWQOS(AWQOS),
    .AWREGION(AWREGION), .AWUSER(AWUSER), .AWREADY(AWREADY),
    .WVALID(WVALID), .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WUSER(WUSER), .WREADY(WREADY),
    .BVALID(BVALID), .BRESP(BRESP), .BID(BID), .BUSER(BUSER), .BREADY(BREADY),
    .ARVALID(ARVALID), .ARADDR(ARADDR), .ARID(ARID), .ARLEN(ARLEN), .ARSIZE(ARSIZE),
    .ARBURST(ARBURST), .ARLOCK(ARLOCK), .ARCACHE(ARCACHE), .ARPROT(ARPROT), .ARQOS(ARQOS),
    .ARREGION(ARREGION), .ARUSER(ARUSER), .ARREADY(ARREADY),
    .RVALID(RVALID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RID(RID), .RUSER(RUSER),
    .RREADY(RREADY)
  );

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
    logic [17:0] id;
    logic [7:0]  user;
  } rexp_t;

  typedef struct packed {
    logic [1:0]  resp;
    logic [17:0] id;
    logic [7:0]  user;
  } bexp_t;

  rexp_t       r_q[$];
  bexp_t       b_q[$];
  logic [31:0] model_mem [MW];
  logic [31:0] wbuf [16];
  int          n_cmp = 0;
  int          n_err = 0;

  function automatic logic [15:0] model_addr(input logic [15:0] base, input logic [2:0] size,
                                             input logic [7:0] len, input logic [1:0] burst,
                                             input int beat);
    int unsigned b, span, lo, off;
    b = base;
    if (burst == 2'b00) return base;
    if (burst == 2'b10) begin
      span = (int'(len) + 1) << size;
      lo   = (b / span) * span;
      off  = (b - lo + (beat << size)) % span;
      return 16'(lo + off);
    end
    return 16'(b + (beat << size));
  endfunction

  function automatic logic model_illegal(input logic [2:0] size, input logic [7:0] len,
                                         input logic [1:0] burst);
    return (size > 3'd2) || (burst == 2'b11) ||
           ((burst == 2'b10) && !(len inside {8'd1, 8'd3, 8'd7, 8'd15}));
  endfunction

  task automatic do_write(input logic [15:0] addr, input logic [17:0] id, input logic [7:0] len,
                          input logic [2:0] size, input logic [1:0] burst, input logic [7:0] user,
                          input logic [3:0] strb, input int early_last);
    bexp_t e, got;
    logic ill, any_dec;
    logic [15:0] a;
    int cyc;
    ill = model_illegal(size, len, burst);
    any_dec = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      a = model_addr(addr, size, len, burst, i);
      if (a >= 16'h1000) any_dec = 1'b1;
      else if (!ill)
        for (int b = 0; b < 4; b++)
          if (strb[b]) model_mem[a[11:2]][8*b +: 8] = wbuf[i][8*b +: 8];
    end
    e.resp = any_dec ? 2'b11 : ((ill || early_last >= 0) ? 2'b10 : 2'b00);
    e.id = id;
    e.user = user;
    b_q.push_back(e);

    @(negedge ACLK);
    AWVALID = 1; AWADDR = addr; AWID = id; AWLEN = len; AWSIZE = size; AWBURST = burst;
    AWUSER = user; AWCACHE = 4'h3; AWPROT = 3'h2;
    cyc = 0;
    while (AWREADY !== 1'b1 && cyc < 50) begin @(negedge ACLK); cyc++; end
    if (AWREADY !== 1'b1) begin
      n_cmp++; n_err++;
      $display("FAIL aw_timeout: AWREADY=%b required 1", AWREADY);
      AWVALID = 0; void'(b_q.pop_front()); return;
    end
    @(negedge ACLK);
    AWVALID = 0;
    n_cmp++;
    if ({WREADY, AWREADY} !== 2'b10) begin
      n_err++;
      $display("FAIL aw_to_w: WREADY,AWREADY=%b required 10", {WREADY, AWREADY});
    end
    for (int i = 0; i <= int'(len); i++) begin
      WVALID = 1; WDATA = wbuf[i]; WSTRB = strb; WUSER = 8'(i);
      WLAST = (i == int'(len)) || (i == early_last);
      cyc = 0;
      while (WREADY !== 1'b1 && cyc < 50) begin @(negedge ACLK); cyc++; end
      @(negedge ACLK);
    end
    WVALID = 0; WLAST = 0;
    n_cmp++;
    if (BVALID !== 1'b1) begin
      n_err++;
      $display("FAIL b_latency: BVALID=%b required 1", BVALID);
    end
    @(negedge ACLK);
    got = {BRESP, BID, BUSER};
    e = b_q.pop_front();
    n_cmp++;
    if (BVALID !== 1'b1 || got !== e) begin
      n_err++;
      $display("FAIL b_resp: BVALID=%b resp/id/user=%h/%h/%h required 1 %h/%h/%h",
               BVALID, BRESP, BID, BUSER, e.resp, e.id, e.user);
    end
    BREADY = 1;
    @(negedge ACLK);
    BREADY = 0;
    n_cmp++;
    if ({BVALID, AWREADY} !== 2'b01) begin
      n_err++;
      $display("FAIL b_done: BVALID,AWREADY=%b required 01", {BVALID, AWREADY});
    end
  endtask

  task automatic do_read(input logic [15:0] addr, input logic [17:0] id, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst, input logic [7:0] user,
                         input bit toggle);
    rexp_t e;
    logic ill;
    logic [15:0] a;
    int cyc, got;
    logic held_v, held_l;
    logic [31:0] held_d;
    ill = model_illegal(size, len, burst);
    for (int i = 0; i <= int'(len); i++) begin
      a = model_addr(addr, size, len, burst, i);
      e.resp = (a >= 16'h1000) ? 2'b11 : (ill ? 2'b10 : 2'b00);
      e.data = (e.resp == 2'b00) ? model_mem[a[11:2]] : 32'h0;
      e.last = (i == int'(len));
      e.id = id;
      e.user = user;
      r_q.push_back(e);
    end

    @(negedge ACLK);
    ARVALID = 1; ARADDR = addr; ARID = id; ARLEN = len; ARSIZE = size; ARBURST = burst;
    ARUSER = user; ARQOS = 4'h5;
    cyc = 0;
    while (ARREADY !== 1'b1 && cyc < 50) begin @(negedge ACLK); cyc++; end
    if (ARREADY !== 1'b1) begin
      n_cmp++; n_err++;
      $display("FAIL ar_timeout: ARREADY=%b required 1", ARREADY);
      ARVALID = 0; r_q.delete(); return;
    end
    @(negedge ACLK);
    ARVALID = 0;
    n_cmp++;
    if (RVALID !== 1'b1) begin
      n_err++;
      $display("FAIL r_latency: RVALID=%b required 1", RVALID);
    end
    got = 0; cyc = 0; held_v = 0; held_d = 0; held_l = 0;
    while (got <= int'(len) && cyc < 200) begin
      RREADY = toggle ? cyc[0] : 1'b1;
      if (held_v) begin
        n_cmp++;
        if (RDATA !== held_d || RLAST !== held_l || RVALID !== 1'b1) begin
          n_err++;
          $display("FAIL r_stall_hold: RDATA=%h RLAST=%b required %h %b", RDATA, RLAST, held_d, held_l);
        end
      end
      held_v = 0;
      if (RVALID === 1'b1 && RREADY) begin
        e = r_q.pop_front();
        n_cmp++;
        if (RDATA !== e.data) begin
          n_err++;
          $display("FAIL r_data beat %0d: RDATA=%h required %h", got, RDATA, e.data);
        end
        n_cmp++;
        if ({RRESP, RLAST, RID, RUSER} !== {e.resp, e.last, e.id, e.user}) begin
          n_err++;
          $display("FAIL r_ctrl beat %0d: resp/last/id/user=%h/%b/%h/%h required %h/%b/%h/%h",
                   got, RRESP, RLAST, RID, RUSER, e.resp, e.last, e.id, e.user);
        end
        got++;
      end else if (RVALID === 1'b1) begin
        held_v = 1; held_d = RDATA; held_l = RLAST;
      end
      @(negedge ACLK);
      cyc++;
    end
    RREADY = 0;
    if (got <= int'(len)) begin
      n_cmp++; n_err++;
      $display("FAIL r_timeout: beats=%0d required %0d", got, int'(len) + 1);
      r_q.delete();
    end
    n_cmp++;
    if ({RVALID, ARREADY} !== 2'b01) begin
      n_err++;
      $display("FAIL r_done: RVALID,ARREADY=%b required 01", {RVALID, ARREADY});
    end
  endtask

  task automatic test_reset();
    ARESETn = 0;
    repeat (3) @(negedge ACLK);
    n_cmp++;
    if ({AWREADY, WREADY, ARREADY, BVALID, RVALID, RLAST} !== 6'b0) begin
      n_err++;
      $display("FAIL reset_ctrl: got %b required 000000",
               {AWREADY, WREADY, ARREADY, BVALID, RVALID, RLAST});
    end
    n_cmp++;
    if ({RDATA, RRESP, RID, RUSER, BRESP, BID, BUSER} !== '0) begin
      n_err++;
      $display("FAIL reset_data: RDATA=%h RRESP=%h RID=%h BRESP=%h BID=%h required 0",
               RDATA, RRESP, RID, BRESP, BID);
    end
    ARESETn = 1;
    #1;
    n_cmp++;
    if ({AWREADY, ARREADY} !== 2'b00) begin
      n_err++;
      $display("FAIL ready_before_edge: got %b required 00", {AWREADY, ARREADY});
    end
    @(negedge ACLK);
    n_cmp++;
    if ({AWREADY, ARREADY} !== 2'b11) begin
      n_err++;
      $display("FAIL ready_after_edge: got %b required 11", {AWREADY, ARREADY});
    end
  endtask

  task automatic test_single();
    wbuf[0] = 32'hDEADBEEF;
    do_write(16'h0010, 18'h2A5A5, 8'd0, 3'd2, 2'b01, 8'h3C, 4'hF, -1);
    do_read(16'h0010, 18'h01234, 8'd0, 3'd2, 2'b01, 8'h77, 1'b0);
  endtask

  task automatic test_incr_stall();
    for (int i = 0; i < 4; i++) wbuf[i] = 32'(i + 1);
    do_write(16'h0100, 18'h00011, 8'd3, 3'd2, 2'b01, 8'h01, 4'hF, -1);
    do_read(16'h0100, 18'h00022, 8'd3, 3'd2, 2'b01, 8'h02, 1'b1);
  endtask

  task automatic test_wrap();
    do_read(16'h0108, 18'h00033, 8'd3, 3'd2, 2'b10, 8'h03, 1'b0);
  endtask

  task automatic test_strobes();
    wbuf[0] = 32'h0;
    do_write(16'h0000, 18'h00044, 8'd0, 3'd2, 2'b01, 8'h04, 4'hF, -1);
    wbuf[0] = 32'hAABBCCDD;
    do_write(16'h0000, 18'h00045, 8'd0, 3'd2, 2'b01, 8'h05, 4'h5, -1);
    do_read(16'h0000, 18'h00046, 8'd0, 3'd2, 2'b01, 8'h06, 1'b0);
  endtask

  task automatic test_errors();
    do_read(16'h1000, 18'h00050, 8'd0, 3'd2, 2'b01, 8'h10, 1'b0);
    wbuf[0] = 32'h11112222;
    do_write(16'h0200, 18'h00051, 8'd0, 3'd2, 2'b01, 8'h11, 4'hF, -1);
    wbuf[0] = 32'h99999999;
    do_write(16'h0200, 18'h00052, 8'd0, 3'd3, 2'b01, 8'h12, 4'hF, -1);
    do_read(16'h0200, 18'h00053, 8'd0, 3'd2, 2'b01, 8'h13, 1'b0);
    for (int i = 0; i < 4; i++) wbuf[i] = 32'(i + 5);
    do_write(16'h0300, 18'h00054, 8'd3, 3'd2, 2'b01, 8'h14, 4'hF, 1);
    do_read(16'h0100, 18'h00055, 8'd2, 3'd2, 2'b10, 8'h15, 1'b0);
    do_read(16'h0100, 18'h00056, 8'd1, 3'd2, 2'b11, 8'h16, 1'b0);
  endtask

  task automatic test_boundary();
    for (int i = 0; i < 4; i++) wbuf[i] = 32'hC0DE0000 + 32'(i);
    do_write(16'h0FF8, 18'h00060, 8'd3, 3'd2, 2'b01, 8'h20, 4'hF, -1);
    do_read(16'h0FF8, 18'h00061, 8'd3, 3'd2, 2'b01, 8'h21, 1'b1);
    do_read(16'hFFFC, 18'h00062, 8'd1, 3'd2, 2'b01, 8'h22, 1'b0);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 2; i++) wbuf[i] = 32'h5A5A0000 + 32'(i);
    fork
      do_write(16'h0400, 18'h00070, 8'd1, 3'd2, 2'b01, 8'h30, 4'hF, -1);
      do_read(16'h0100, 18'h00071, 8'd3, 3'd2, 2'b00, 8'h31, 1'b0);
    join
    do_read(16'h0400, 18'h00072, 8'd1, 3'd2, 2'b01, 8'h32, 1'b0);
  endtask

  task automatic test_reset_mid_read();
    int cyc;
    @(negedge ACLK);
    ARVALID = 1; ARADDR = 16'h0100; ARID = 18'h00080; ARLEN = 8'd3; ARSIZE = 3'd2;
    ARBURST = 2'b01; ARUSER = 8'h40;
    RREADY = 1;
    cyc = 0;
    while (ARREADY !== 1'b1 && cyc < 50) begin @(negedge ACLK); cyc++; end
    @(negedge ACLK);
    ARVALID = 0;
    @(negedge ACLK);
    n_cmp++;
    if (RVALID !== 1'b1 || RDATA !== 32'd2) begin
      n_err++;
      $display("FAIL mid_read_beat2: RVALID=%b RDATA=%h required 1 00000002", RVALID, RDATA);
    end
    #2 ARESETn = 0;
    #1;
    n_cmp++;
    if ({RVALID, RLAST, ARREADY, RDATA} !== '0) begin
      n_err++;
      $display("FAIL reset_abort: RVALID=%b RLAST=%b ARREADY=%b RDATA=%h required 0",
               RVALID, RLAST, ARREADY, RDATA);
    end
    RREADY = 0;
    @(negedge ACLK);
    ARESETn = 1;
    @(negedge ACLK);
    do_read(16'h0100, 18'h00081, 8'd0, 3'd2, 2'b01, 8'h41, 1'b0);
    do_read(16'h0010, 18'h00082, 8'd0, 3'd2, 2'b01, 8'h42, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    test_incr_stall();
    test_wrap();
    test_strobes();
    test_errors();
    test_boundary();
    test_back_to_back();
    test_reset_mid_read();
    repeat (2) @(negedge ACLK);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
